// File: rtl/obi_rr_arbiter.sv
// Round-robin N:1 OBI arbiter: zero-latency request forwarding with the selection
// locked until granted, plus an in-order source-ID FIFO that routes responses back.
module obi_rr_arbiter #(
  parameter int NR_REQ  = 2,
  parameter int MAX_OUT = 2,
  parameter int OBI_AW  = 32,
  parameter int OBI_DW  = 32
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [NR_REQ-1:0]          init_req_i,
  output logic [NR_REQ-1:0]          init_gnt_o,
  input  logic [NR_REQ-1:0]          init_we_i,
  input  logic [NR_REQ*OBI_AW-1:0]   init_addr_i,
  input  logic [NR_REQ*OBI_DW/8-1:0] init_be_i,
  input  logic [NR_REQ*OBI_DW-1:0]   init_wdata_i,
  output logic [NR_REQ-1:0]          init_rvalid_o,
  output logic [NR_REQ-1:0]          init_err_o,
  output logic [OBI_DW-1:0]          init_rdata_o,
  output logic                       tgt_req_o,
  output logic                       tgt_reqpar_o,
  input  logic                       tgt_gnt_i,
  output logic                       tgt_we_o,
  output logic [OBI_AW-1:0]          tgt_addr_o,
  output logic [OBI_DW/8-1:0]        tgt_be_o,
  output logic [OBI_DW-1:0]          tgt_wdata_o,
  input  logic                       tgt_rvalid_i,
  input  logic                       tgt_err_i,
  input  logic [OBI_DW-1:0]          tgt_rdata_i,
  output logic                       busy_o
);

  localparam int BW = OBI_DW / 8;
  localparam int SW = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  typedef enum logic {UNLOCKED, LOCKED} state_e;

  state_e          r_state;
  logic [SW-1:0]   r_sel;
  logic [SW-1:0]   r_rr_ptr;
  logic [CW-1:0]   r_cnt;
  logic [SW-1:0]   r_fifo [MAX_OUT];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;

  logic [OBI_AW-1:0] w_addr  [NR_REQ];
  logic [BW-1:0]     w_be    [NR_REQ];
  logic [OBI_DW-1:0] w_wdata [NR_REQ];
  logic [SW-1:0]     w_pick;
  logic              w_pick_vld;
  logic [SW-1:0]     w_winner;
  logic [SW-1:0]     w_next_ptr;
  logic [SW-1:0]     w_head;
  logic              w_full;
  logic              w_req;
  logic              w_hs;
  logic              w_rsp;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    for (int k = 0; k < NR_REQ; k++) begin
      w_addr[k]  = init_addr_i[k*OBI_AW +: OBI_AW];
      w_be[k]    = init_be_i[k*BW +: BW];
      w_wdata[k] = init_wdata_i[k*OBI_DW +: OBI_DW];
    end
  end

  // First asserted request scanning upward from the round-robin pointer.
  always_comb begin
    int idx;
    w_pick     = '0;
    w_pick_vld = 1'b0;
    for (int i = 0; i < NR_REQ; i++) begin
      idx = int'(r_rr_ptr) + i;
      if (idx >= NR_REQ) idx = idx - NR_REQ;
      if (!w_pick_vld && init_req_i[idx]) begin
        w_pick_vld = 1'b1;
        w_pick     = SW'(idx);
      end
    end
  end

  assign w_full     = (r_cnt == CW'(MAX_OUT));
  assign w_winner   = (r_state == LOCKED) ? r_sel : w_pick;
  assign w_req      = rstn_i & ((r_state == LOCKED) | (~w_full & w_pick_vld));
  assign w_hs       = w_req & tgt_gnt_i;
  assign w_next_ptr = (w_winner == SW'(NR_REQ - 1)) ? '0 : w_winner + SW'(1);
  assign w_head     = r_fifo[r_rptr];
  assign w_rsp      = rstn_i & tgt_rvalid_i & (r_cnt != '0);

  always_comb begin
    init_gnt_o    = '0;
    init_rvalid_o = '0;
    init_err_o    = '0;
    tgt_we_o      = 1'b0;
    tgt_addr_o    = '0;
    tgt_be_o      = '0;
    tgt_wdata_o   = '0;
    if (w_hs) init_gnt_o[w_winner] = 1'b1;
    if (w_rsp) begin
      init_rvalid_o[w_head] = 1'b1;
      init_err_o[w_head]    = tgt_err_i;
    end
    if (w_req) begin
      tgt_we_o    = init_we_i[w_winner];
      tgt_addr_o  = w_addr[w_winner];
      tgt_be_o    = w_be[w_winner];
      tgt_wdata_o = w_wdata[w_winner];
    end
  end

  assign tgt_req_o    = w_req;
  assign tgt_reqpar_o = ~w_req;
  assign init_rdata_o = tgt_rdata_i;
  assign busy_o       = rstn_i & (r_cnt != '0);

  // FIFO storage is left unreset; only the pointers and count define its contents.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state  <= UNLOCKED;
      r_sel    <= '0;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
    end else begin
      if (w_hs) begin
        r_fifo[r_wptr] <= w_winner;
        r_wptr         <= ptr_inc(r_wptr);
        r_rr_ptr       <= w_next_ptr;
        r_state        <= UNLOCKED;
      end else if (w_req && r_state == UNLOCKED) begin
        r_state <= LOCKED;
        r_sel   <= w_winner;
      end
      if (w_rsp) r_rptr <= ptr_inc(r_rptr);
      case ({w_hs, w_rsp})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Self-checking bench for obi_rr_arbiter: directed vector table, hand-written
// lock sequence, then random traffic against a queue-based reference model.
module tb_obi_rr_arbiter;
  localparam int NR = 2;
  localparam int MO = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn;
  logic [NR-1:0]     init_req, init_gnt, init_we, init_rvalid, init_err;
  logic [NR*AW-1:0]  init_addr;
  logic [NR*BW-1:0]  init_be;
  logic [NR*DW-1:0]  init_wdata;
  logic [DW-1:0]     init_rdata;
  logic              tgt_req, tgt_reqpar, tgt_gnt, tgt_we, tgt_rvalid, tgt_err, busy;
  logic [AW-1:0]     tgt_addr;
  logic [BW-1:0]     tgt_be;
  logic [DW-1:0]     tgt_wdata, tgt_rdata;

  logic [AW-1:0] a  [NR];
  logic          we [NR];
  logic [BW-1:0] be [NR];
  logic [DW-1:0] wd [NR];

  for (genvar k = 0; k < NR; k++) begin : g_pack
    assign init_addr[k*AW +: AW]  = a[k];
    assign init_we[k]             = we[k];
    assign init_be[k*BW +: BW]    = be[k];
    assign init_wdata[k*DW +: DW] = wd[k];
  end

  obi_rr_arbiter #(.NR_REQ(NR), .MAX_OUT(MO), .OBI_AW(AW), .OBI_DW(DW)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .init_req_i(init_req), .init_gnt_o(init_gnt), .init_we_i(init_we),
    .init_addr_i(init_addr), .init_be_i(init_be), .init_wdata_i(init_wdata),
    .init_rvalid_o(init_rvalid), .init_err_o(init_err), .init_rdata_o(init_rdata),
    .tgt_req_o(tgt_req), .tgt_reqpar_o(tgt_reqpar), .tgt_gnt_i(tgt_gnt),
    .tgt_we_o(tgt_we), .tgt_addr_o(tgt_addr), .tgt_be_o(tgt_be), .tgt_wdata_o(tgt_wdata),
    .tgt_rvalid_i(tgt_rvalid), .tgt_err_i(tgt_err), .tgt_rdata_i(tgt_rdata),
    .busy_o(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rstn;
    logic [1:0]  req;
    logic        gnt, rv, err;
    logic        e_treq;
    logic [1:0]  e_gnt, e_rv, e_err;
    logic        e_busy;
    logic [31:0] e_addr;
  } vec_t;
  vec_t vt[$];

  task automatic addv(input logic rs, input logic [1:0] rq, input logic g, input logic v,
                      input logic e, input logic et, input logic [1:0] eg, input logic [1:0] ev,
                      input logic [1:0] ee, input logic eb, input logic [31:0] ea);
    vec_t x;
    x.rstn = rs; x.req = rq; x.gnt = g; x.rv = v; x.err = e;
    x.e_treq = et; x.e_gnt = eg; x.e_rv = ev; x.e_err = ee; x.e_busy = eb; x.e_addr = ea;
    vt.push_back(x);
  endtask

  task automatic hs(input logic [1:0] rq, input logic g, input logic v, input logic et,
                    input logic [1:0] eg, input logic [1:0] ev, input logic eb,
                    input logic [31:0] ea);
    init_req = rq; tgt_gnt = g; tgt_rvalid = v; tgt_err = 1'b0;
    @(negedge clk);
    chk("lk_treq", tgt_req, et);
    chk("lk_gnt", init_gnt, eg);
    chk("lk_rvalid", init_rvalid, ev);
    chk("lk_busy", busy, eb);
    chk("lk_addr", tgt_addr, ea);
    @(posedge clk); #1;
  endtask

  initial begin
    rstn = 1'b0; init_req = '0; tgt_gnt = 1'b0; tgt_rvalid = 1'b0; tgt_err = 1'b0;
    tgt_rdata = '0;
    a[0] = 32'h1000; a[1] = 32'h2000;
    for (int k = 0; k < NR; k++) begin we[k] = 1'b0; be[k] = 4'hF; wd[k] = '0; end

    //    rstn req  gnt rv err | treq gnt   rv    err   busy addr
    addv(0, 2'b11, 1, 0, 0,    0, 2'b00, 2'b00, 2'b00, 0, 32'h0);     // reset
    addv(0, 2'b11, 1, 0, 0,    0, 2'b00, 2'b00, 2'b00, 0, 32'h0);
    addv(1, 2'b11, 1, 0, 0,    1, 2'b01, 2'b00, 2'b00, 0, 32'h1000);  // fairness
    addv(1, 2'b11, 1, 1, 0,    1, 2'b10, 2'b01, 2'b00, 1, 32'h2000);  // gnt1 + rsp0
    addv(1, 2'b11, 1, 1, 0,    1, 2'b01, 2'b10, 2'b00, 1, 32'h1000);
    addv(1, 2'b11, 1, 1, 0,    1, 2'b10, 2'b01, 2'b00, 1, 32'h2000);
    addv(1, 2'b00, 1, 1, 0,    0, 2'b00, 2'b10, 2'b00, 1, 32'h0);
    addv(1, 2'b10, 1, 0, 0,    1, 2'b10, 2'b00, 2'b00, 0, 32'h2000);  // error
    addv(1, 2'b00, 0, 1, 1,    0, 2'b00, 2'b10, 2'b10, 1, 32'h0);
    addv(1, 2'b01, 1, 0, 0,    1, 2'b01, 2'b00, 2'b00, 0, 32'h1000);  // fill up
    addv(1, 2'b01, 1, 0, 0,    1, 2'b01, 2'b00, 2'b00, 1, 32'h1000);
    addv(1, 2'b10, 1, 0, 0,    0, 2'b00, 2'b00, 2'b00, 1, 32'h0);     // full
    addv(1, 2'b10, 1, 1, 0,    0, 2'b00, 2'b01, 2'b00, 1, 32'h0);     // no bypass
    addv(1, 2'b10, 1, 0, 0,    1, 2'b10, 2'b00, 2'b00, 1, 32'h2000);
    addv(1, 2'b00, 0, 1, 0,    0, 2'b00, 2'b01, 2'b00, 1, 32'h0);
    addv(1, 2'b00, 0, 1, 0,    0, 2'b00, 2'b10, 2'b00, 1, 32'h0);
    addv(1, 2'b00, 0, 1, 0,    0, 2'b00, 2'b00, 2'b00, 0, 32'h0);     // spurious
    addv(1, 2'b01, 1, 0, 0,    1, 2'b01, 2'b00, 2'b00, 0, 32'h1000);
    addv(0, 2'b00, 0, 0, 0,    0, 2'b00, 2'b00, 2'b00, 0, 32'h0);     // reset mid-op
    addv(1, 2'b00, 0, 1, 0,    0, 2'b00, 2'b00, 2'b00, 0, 32'h0);
    addv(1, 2'b11, 1, 0, 0,    1, 2'b01, 2'b00, 2'b00, 0, 32'h1000);  // rr_ptr back to 0
    addv(1, 2'b00, 0, 1, 0,    0, 2'b00, 2'b01, 2'b00, 1, 32'h0);

    for (int i = 0; i < vt.size(); i++) begin
      rstn = vt[i].rstn; init_req = vt[i].req; tgt_gnt = vt[i].gnt;
      tgt_rvalid = vt[i].rv; tgt_err = vt[i].err; tgt_rdata = 32'hA5A50000 + i;
      @(negedge clk);
      chk("tv_treq", tgt_req, vt[i].e_treq);
      chk("tv_reqpar", tgt_reqpar, !vt[i].e_treq);
      chk("tv_gnt", init_gnt, vt[i].e_gnt);
      chk("tv_rvalid", init_rvalid, vt[i].e_rv);
      chk("tv_err", init_err, vt[i].e_err);
      chk("tv_busy", busy, vt[i].e_busy);
      chk("tv_addr", tgt_addr, vt[i].e_addr);
      if (vt[i].e_rv != 2'b00) chk("tv_rdata", init_rdata, 32'hA5A50000 + i);
      @(posedge clk); #1;
    end

    // Lock: req0 stalled 3 cycles, req1 rises meanwhile (rr_ptr is 1 here).
    hs(2'b01, 0, 0, 1, 2'b00, 2'b00, 0, 32'h1000);
    hs(2'b11, 0, 0, 1, 2'b00, 2'b00, 0, 32'h1000);
    hs(2'b11, 0, 0, 1, 2'b00, 2'b00, 0, 32'h1000);
    hs(2'b11, 1, 0, 1, 2'b01, 2'b00, 0, 32'h1000);
    hs(2'b10, 1, 0, 1, 2'b10, 2'b00, 1, 32'h2000);
    hs(2'b00, 0, 1, 0, 2'b00, 2'b01, 1, 32'h0);
    hs(2'b00, 0, 1, 0, 2'b00, 2'b10, 1, 32'h0);
    hs(2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 32'h0);

    // Random traffic against a queue model of outstanding source IDs.
    begin
      int q[$];
      int rr, lk, sel;
      logic pend [NR];
      rr = 0; lk = 0; sel = 0;
      for (int k = 0; k < NR; k++) pend[k] = 1'b0;
      rstn = 1'b0; init_req = '0;
      @(posedge clk); @(posedge clk); #1;
      for (int c = 0; c < 3000; c++) begin
        int win;
        logic e_treq, rsp;
        logic [1:0] e_gnt, e_rv, e_err;
        for (int k = 0; k < NR; k++) begin
          if (!pend[k] && $urandom_range(0, 2) == 0) begin
            pend[k] = 1'b1; a[k] = $urandom; we[k] = 1'($urandom_range(0, 1));
            be[k] = 4'($urandom); wd[k] = $urandom;
          end
        end
        init_req = {pend[1], pend[0]};
        rstn = ($urandom_range(0, 149) != 0);
        tgt_gnt = 1'($urandom_range(0, 1));
        tgt_rvalid = ($urandom_range(0, 2) != 0);
        tgt_err = 1'($urandom_range(0, 1));
        tgt_rdata = $urandom;

        win = -1;
        if (rstn) begin
          if (lk != 0) win = sel;
          else if (q.size() < MO)
            for (int k = 0; k < NR; k++)
              if (win < 0 && init_req[(rr + k) % NR]) win = (rr + k) % NR;
        end
        e_treq = (win >= 0);
        e_gnt = '0; e_rv = '0; e_err = '0;
        if (e_treq && tgt_gnt) e_gnt[win] = 1'b1;
        rsp = rstn && tgt_rvalid && q.size() > 0;
        if (rsp) begin e_rv[q[0]] = 1'b1; e_err[q[0]] = tgt_err; end

        @(negedge clk);
        chk("rnd_treq", tgt_req, e_treq);
        chk("rnd_reqpar", tgt_reqpar, !e_treq);
        chk("rnd_gnt", init_gnt, e_gnt);
        chk("rnd_rvalid", init_rvalid, e_rv);
        chk("rnd_err", init_err, e_err);
        chk("rnd_busy", busy, rstn && q.size() > 0);
        if (e_treq) begin
          chk("rnd_addr", tgt_addr, a[win]);
          chk("rnd_we", tgt_we, we[win]);
          chk("rnd_be", tgt_be, be[win]);
          chk("rnd_wdata", tgt_wdata, wd[win]);
        end else begin
          chk("rnd_idle_fields", {tgt_we, tgt_be, tgt_addr}, 64'h0);
          chk("rnd_idle_wdata", tgt_wdata, 64'h0);
        end
        if (rsp) chk("rnd_rdata", init_rdata, tgt_rdata);

        if (!rstn) begin
          q.delete(); rr = 0; lk = 0;
        end else begin
          if (rsp) void'(q.pop_front());
          if (e_gnt != 2'b00) begin
            q.push_back(win); rr = (win + 1) % NR; lk = 0; pend[win] = 1'b0;
          end else if (e_treq) begin
            lk = 1; sel = win;
          end
        end
        @(posedge clk); #1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
